// File: rtl/seg7_scan_capture_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_scan_capture_pkg : segment patterns, special codes, FSM encodings
// Revision: 1.0
// ---------------------------------------------------------------------------
package seg7_scan_capture_pkg;

    // Active-low patterns, bit6=a ... bit0=g
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK   = 4'hE;
    localparam logic [3:0] CODE_ILLEGAL = 4'hF;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/seg7_scan_capture_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_pattern_encoder : active-low 7-segment pattern to BCD code + illegal flag
// Revision: 1.0
// ---------------------------------------------------------------------------
module seg7_pattern_encoder
    import seg7_scan_capture_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       illegal
);

    always_comb begin
        code = CODE_ILLEGAL;
        case (pattern)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default:   code = CODE_ILLEGAL;
        endcase
        illegal = (code == CODE_ILLEGAL);
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_scan_capture : recovers BCD digits from a multiplexed active-low display
// Revision: 1.0
// ---------------------------------------------------------------------------
module seg7_scan_capture
    import seg7_scan_capture_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SETTLE     = 2,
    parameter int STABLE_CNT = 3,
    localparam int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     an,
    input  logic                  err_clr,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  valid,
    output logic                  err,
    output logic [IDX_W-1:0]      err_digit
);

    localparam logic [DIGITS-1:0] ONE_D = DIGITS'(1);

    logic [DIGITS-1:0]   an_q;
    logic [DIGITS-1:0]   an_prev;
    logic [DIGITS-1:0]   an_low;
    logic                an_changed;
    logic                sel_legal;
    logic [IDX_W-1:0]    sel_idx;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [3:0]          settle_cnt;
    logic [3:0]          settle_cnt_nxt;
    logic                sample;

    logic [3:0]          code;
    logic                code_illegal;

    logic [4*DIGITS-1:0] frame_buf;
    logic [4*DIGITS-1:0] prev_frame;
    logic [DIGITS-1:0]   cap_flags;
    logic [DIGITS-1:0]   cap_flags_nxt;
    logic                first_frame;
    logic [3:0]          match_cnt;
    logic [3:0]          match_nxt;
    logic                frame_done;
    logic                frame_has_ill;
    logic                do_update;

    seg7_pattern_encoder u_encoder (
        .pattern (seg),
        .code    (code),
        .illegal (code_illegal)
    );

    // A select is legal when exactly one enable is driven low.
    always_comb begin
        an_low     = ~an_q;
        an_changed = (an_q != an_prev);
        sel_legal  = (an_low != '0) && ((an_low & (an_low - ONE_D)) == '0);
        sel_idx    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_q[i]) sel_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q       <= '1;
            an_prev    <= '1;
            state      <= ST_IDLE;
            settle_cnt <= 4'd0;
        end else begin
            an_q       <= an;
            an_prev    <= an_q;
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        case (state)
            ST_IDLE: begin
                if (sel_legal) begin
                    state_nxt      = ST_SETTLE;
                    settle_cnt_nxt = 4'd1;
                end
            end
            ST_SETTLE: begin
                if (an_changed) begin
                    settle_cnt_nxt = 4'd1;
                    state_nxt      = sel_legal ? ST_SETTLE : ST_IDLE;
                end else if (settle_cnt == 4'(SETTLE)) begin
                    state_nxt = ST_HOLD;
                end else begin
                    settle_cnt_nxt = settle_cnt + 4'd1;
                end
            end
            ST_HOLD: begin
                if (an_changed) begin
                    settle_cnt_nxt = 4'd1;
                    state_nxt      = sel_legal ? ST_SETTLE : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sample = (state == ST_SETTLE) && !an_changed && (settle_cnt == 4'(SETTLE));
    end

    // Frame bookkeeping: a sample landing on the completion edge still sets its flag.
    always_comb begin
        frame_done    = &cap_flags;
        cap_flags_nxt = frame_done ? '0 : cap_flags;
        if (sample) cap_flags_nxt[sel_idx] = 1'b1;

        frame_has_ill = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (frame_buf[4*i +: 4] == CODE_ILLEGAL) frame_has_ill = 1'b1;
        end

        if (first_frame || (frame_buf != prev_frame)) begin
            match_nxt = 4'd1;
        end else if (match_cnt == 4'd15) begin
            match_nxt = 4'd15;
        end else begin
            match_nxt = match_cnt + 4'd1;
        end

        do_update = (match_nxt == 4'(STABLE_CNT)) && !frame_has_ill && (frame_buf != bcd_out);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_buf   <= '0;
            prev_frame  <= '0;
            cap_flags   <= '0;
            first_frame <= 1'b1;
            match_cnt   <= 4'd0;
            bcd_out     <= '0;
            valid       <= 1'b0;
            err         <= 1'b0;
            err_digit   <= '0;
        end else begin
            valid     <= 1'b0;
            cap_flags <= cap_flags_nxt;
            if (err_clr) err <= 1'b0;
            if (frame_done) begin
                match_cnt   <= match_nxt;
                prev_frame  <= frame_buf;
                first_frame <= 1'b0;
                if (do_update) begin
                    bcd_out <= frame_buf;
                    valid   <= 1'b1;
                end
            end
            // A new illegal sample takes priority over a coincident clear.
            if (sample) begin
                frame_buf[{sel_idx, 2'b00} +: 4] <= code;
                if (code_illegal) begin
                    err       <= 1'b1;
                    err_digit <= sel_idx;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seg7_scan_capture : directed scan stimulus with an expected-update queue
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seg7_scan_capture;
    import seg7_scan_capture_pkg::*;

    localparam logic [6:0] SEG_BAD = 7'b0110110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        err_clr;
    logic [15:0] bcd_out;
    logic        valid;
    logic        err;
    logic [1:0]  err_digit;

    int          total = 0;
    int          bad = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_v;

    always #5 clk = ~clk;

    seg7_scan_capture #(
        .DIGITS     (4),
        .SETTLE     (2),
        .STABLE_CNT (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg       (seg),
        .an        (an),
        .err_clr   (err_clr),
        .bcd_out   (bcd_out),
        .valid     (valid),
        .err       (err),
        .err_digit (err_digit)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Every valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_valid: observed bcd_out=%0h expected no pulse", bcd_out);
            end
            if (sb.size() != 0) begin
                exp_v = sb.pop_front();
                check("valid_bcd", {16'h0, bcd_out}, {16'h0, exp_v});
            end
        end
    end

    task automatic show(input int idx, input logic [6:0] pat, input int cycles);
        an  = ~(4'b0001 << idx);
        seg = pat;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic frame(input logic [6:0] p0, input logic [6:0] p1,
                         input logic [6:0] p2, input logic [6:0] p3);
        show(0, p0, 8);
        show(1, p1, 8);
        show(2, p2, 8);
        show(3, p3, 8);
    endtask

    initial begin
        rst_n   = 1'b0;
        seg     = SEG_BLANK;
        an      = 4'hF;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bcd", {16'h0, bcd_out}, 32'h0);
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_err_digit", {30'h0, err_digit}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // "1259": update only on the third identical frame
        frame(SEG_1, SEG_2, SEG_5, SEG_9);
        frame(SEG_1, SEG_2, SEG_5, SEG_9);
        check("early_bcd", {16'h0, bcd_out}, 32'h0);
        sb.push_back(16'h9521);
        frame(SEG_1, SEG_2, SEG_5, SEG_9);
        check("scan_1259_pending", sb.size(), 0);
        check("scan_1259_bcd", {16'h0, bcd_out}, 32'h9521);
        frame(SEG_1, SEG_2, SEG_5, SEG_9);
        check("no_repeat_bcd", {16'h0, bcd_out}, 32'h9521);

        // Digit0 changes to 9, with an interleaved old frame restarting the count
        frame(SEG_9, SEG_2, SEG_5, SEG_9);
        frame(SEG_9, SEG_2, SEG_5, SEG_9);
        frame(SEG_1, SEG_2, SEG_5, SEG_9);
        frame(SEG_9, SEG_2, SEG_5, SEG_9);
        frame(SEG_9, SEG_2, SEG_5, SEG_9);
        check("restart_bcd", {16'h0, bcd_out}, 32'h9521);
        sb.push_back(16'h9529);
        frame(SEG_9, SEG_2, SEG_5, SEG_9);
        check("change_pending", sb.size(), 0);
        check("change_bcd", {16'h0, bcd_out}, 32'h9529);

        // Glitches: a one-cycle select, a multi-low select, and blanking never sample
        show(0, SEG_BAD, 1);
        show(1, SEG_2, 8);
        check("glitch_err", {31'h0, err}, 32'h0);
        an  = 4'b1100;
        seg = SEG_BAD;
        repeat (8) @(negedge clk);
        an = 4'hF;
        repeat (8) @(negedge clk);
        check("multi_low_err", {31'h0, err}, 32'h0);

        // Illegal pattern on digit2: sticky error, no update
        frame(SEG_9, SEG_2, SEG_BAD, SEG_9);
        frame(SEG_9, SEG_2, SEG_BAD, SEG_9);
        frame(SEG_9, SEG_2, SEG_BAD, SEG_9);
        check("illegal_err", {31'h0, err}, 32'h1);
        check("illegal_err_digit", {30'h0, err_digit}, 32'h2);
        check("illegal_bcd", {16'h0, bcd_out}, 32'h9529);
        an = 4'hF;
        repeat (3) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        check("err_clr", {31'h0, err}, 32'h0);

        // err_clr coincident with the sampling edge of an illegal digit1
        show(0, SEG_9, 8);
        an  = 4'b1101;
        seg = SEG_BAD;
        repeat (3) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        repeat (4) @(negedge clk);
        check("coincide_err", {31'h0, err}, 32'h1);
        check("coincide_err_digit", {30'h0, err_digit}, 32'h1);
        show(2, SEG_5, 8);
        show(3, SEG_9, 8);
        an = 4'hF;
        repeat (3) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // Blank digit3 is a legal code
        frame(SEG_0, SEG_0, SEG_0, SEG_BLANK);
        frame(SEG_0, SEG_0, SEG_0, SEG_BLANK);
        sb.push_back(16'hE000);
        frame(SEG_0, SEG_0, SEG_0, SEG_BLANK);
        check("blank_pending", sb.size(), 0);
        check("blank_bcd", {16'h0, bcd_out}, 32'hE000);
        check("blank_err", {31'h0, err}, 32'h0);

        // Reset in the middle of a frame
        show(0, SEG_1, 8);
        show(1, SEG_BAD, 8);
        check("pre_rst_err", {31'h0, err}, 32'h1);
        show(2, SEG_3, 3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_bcd", {16'h0, bcd_out}, 32'h0);
        check("midrst_valid", {31'h0, valid}, 32'h0);
        check("midrst_err", {31'h0, err}, 32'h0);
        check("midrst_err_digit", {30'h0, err_digit}, 32'h0);
        an = 4'hF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame(SEG_1, SEG_2, SEG_5, SEG_9);
        frame(SEG_1, SEG_2, SEG_5, SEG_9);
        check("post_rst_early_bcd", {16'h0, bcd_out}, 32'h0);
        sb.push_back(16'h9521);
        frame(SEG_1, SEG_2, SEG_5, SEG_9);
        check("post_rst_pending", sb.size(), 0);
        check("post_rst_bcd", {16'h0, bcd_out}, 32'h9521);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
